// File: rtl/hazard_stall_controller.sv
// Load-use / branch / MDU hazard controller with MDU busy-done sequencing.
// Optional macro STALL_STATS_EN adds a saturating stall-cycle counter on stall_count.
module hazard_stall_controller #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        MemReadE,
    input  logic        RegWriteE,
    input  logic [4:0]  wb_addrE,
    input  logic        MemtoRegM,
    input  logic [4:0]  wb_addrM,
    input  logic [4:0]  rs_addrD,
    input  logic [4:0]  rt_addrD,
    input  logic        UsesRtD,
    input  logic        BranchD,
    input  logic        BranchTakenD,
    input  logic        MduStartD,
    input  logic        MduDivD,
    input  logic        HiLoReadD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        MduBusy,
`ifdef STALL_STATS_EN
    output logic [15:0] stall_count,
`endif
    output logic        MduDone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_e_rs, w_e_rt, w_m_rs, w_m_rt;
    logic w_lu_hazard, w_br_hazard, w_mdu_hazard, w_stall;

    // Register $0 is hardwired, so a zero address never creates a dependency.
    assign w_e_rs = (wb_addrE != 5'd0) && (wb_addrE == rs_addrD);
    assign w_e_rt = (wb_addrE != 5'd0) && (wb_addrE == rt_addrD);
    assign w_m_rs = (wb_addrM != 5'd0) && (wb_addrM == rs_addrD);
    assign w_m_rt = (wb_addrM != 5'd0) && (wb_addrM == rt_addrD);

    assign w_lu_hazard  = MemReadE & (w_e_rs | (UsesRtD & w_e_rt));
    assign w_br_hazard  = BranchD & ((RegWriteE & (w_e_rs | w_e_rt)) |
                                     (MemtoRegM & (w_m_rs | w_m_rt)));
    assign w_mdu_hazard = (r_state != S_IDLE) & (MduStartD | HiLoReadD);
    assign w_stall      = RESET_N & (w_lu_hazard | w_br_hazard | w_mdu_hazard);

    assign StallF  = w_stall;
    assign StallD  = w_stall;
    assign FlushE  = w_stall;
    assign FlushD  = RESET_N & BranchTakenD & ~w_stall;
    assign MduBusy = RESET_N & (r_state == S_RUN);
    assign MduDone = RESET_N & (r_state == S_DONE);

    // MDU sequencer: counter runs N-1 down to 0 in RUN, then one DONE cycle.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MduStartD && !w_stall) begin
                        r_state <= S_RUN;
                        r_cnt   <= MduDivD ? DIV_LOAD : MULT_LOAD;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) r_state <= S_DONE;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef STALL_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N)                                  r_stall_count <= '0;
        else if (w_stall && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Table-driven and sequence checks for hazard_stall_controller with a scoreboard queue.
module tb_hazard_stall_controller;

    localparam int unsigned MULT_N = 4;
    localparam int unsigned DIV_N  = 32;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic       RESET_N;
    logic       MemReadE, RegWriteE, MemtoRegM, UsesRtD, BranchD, BranchTakenD;
    logic       MduStartD, MduDivD, HiLoReadD;
    logic [4:0] wb_addrE, wb_addrM, rs_addrD, rt_addrD;
    logic       StallF, StallD, FlushD, FlushE, MduBusy, MduDone;
`ifdef STALL_STATS_EN
    logic [15:0] stall_count;
`endif

    hazard_stall_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .MemReadE(MemReadE), .RegWriteE(RegWriteE), .wb_addrE(wb_addrE),
        .MemtoRegM(MemtoRegM), .wb_addrM(wb_addrM),
        .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .UsesRtD(UsesRtD),
        .BranchD(BranchD), .BranchTakenD(BranchTakenD),
        .MduStartD(MduStartD), .MduDivD(MduDivD), .HiLoReadD(HiLoReadD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MduBusy(MduBusy),
`ifdef STALL_STATS_EN
        .stall_count(stall_count),
`endif
        .MduDone(MduDone)
    );

    typedef struct packed {
        logic       mem_read_e;
        logic       reg_write_e;
        logic [4:0] wb_e;
        logic       memtoreg_m;
        logic [4:0] wb_m;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       branch;
        logic       taken;
        logic       mdu_start;
        logic       mdu_div;
        logic       hilo;
    } vin_t;

    typedef struct packed {
        logic stall;
        logic flush_d;
        logic busy;
        logic done;
    } vexp_t;

    typedef struct packed {
        vin_t  vi;
        vexp_t ve;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    vexp_t exp_q[$];
    string name_q[$];

    function automatic vin_t mkin(input logic mr, input logic rw, input logic [4:0] wbe,
                                  input logic mm, input logic [4:0] wbm,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                                  input logic br, input logic tk, input logic ms,
                                  input logic md, input logic hl);
        vin_t v;
        v.mem_read_e = mr; v.reg_write_e = rw; v.wb_e = wbe;
        v.memtoreg_m = mm; v.wb_m = wbm; v.rs = rs; v.rt = rt; v.uses_rt = ut;
        v.branch = br; v.taken = tk; v.mdu_start = ms; v.mdu_div = md; v.hilo = hl;
        return v;
    endfunction

    function automatic vexp_t mkexp(input logic s, input logic f, input logic b, input logic d);
        vexp_t e;
        e.stall = s; e.flush_d = f; e.busy = b; e.done = d;
        return e;
    endfunction

    task automatic drive(input vin_t v);
        MemReadE = v.mem_read_e; RegWriteE = v.reg_write_e; wb_addrE = v.wb_e;
        MemtoRegM = v.memtoreg_m; wb_addrM = v.wb_m;
        rs_addrD = v.rs; rt_addrD = v.rt; UsesRtD = v.uses_rt;
        BranchD = v.branch; BranchTakenD = v.taken;
        MduStartD = v.mdu_start; MduDivD = v.mdu_div; HiLoReadD = v.hilo;
    endtask

    task automatic compare_out();
        vexp_t      e;
        string      nm;
        logic [5:0] got, want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: output observed with no expectation queued");
        end else begin
            e    = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {StallF, StallD, FlushD, FlushE, MduBusy, MduDone};
            want = {e.stall, e.stall, e.flush_d, e.stall, e.busy, e.done};
            if (got !== want) begin
                errors++;
                $display("FAIL %s at %0t: {StallF,StallD,FlushD,FlushE,Busy,Done} got %b want %b",
                         nm, $time, got, want);
            end
        end
    endtask

    // One pipeline cycle: drive just after posedge, check at negedge.
    task automatic cyc(input vin_t v, input vexp_t e, input string nm);
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge CLOCK);
        compare_out();
        @(posedge CLOCK);
        #1;
    endtask

`ifdef STALL_STATS_EN
    task automatic check_count(input logic [15:0] want, input string nm);
        checks++;
        if (stall_count !== want) begin
            errors++;
            $display("FAIL %s: stall_count got %h want %h", nm, stall_count, want);
        end
    endtask
`endif

    vec_t  tbl[14];
    vin_t  z, lu, hl;
    vexp_t none;

    initial begin
        z    = mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0);
        lu   = mkin(1,1,5'd5,0,5'd0,5'd5,5'd0,0,0,0,0,0,0);
        hl   = mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,0,1);
        none = mkexp(0,0,0,0);

        tbl[0]  = '{mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0),  mkexp(0,0,0,0)};
        tbl[1]  = '{mkin(1,1,5'd5,0,5'd0,5'd5,5'd0,0,0,0,0,0,0),  mkexp(1,0,0,0)};
        tbl[2]  = '{mkin(1,1,5'd0,0,5'd0,5'd0,5'd0,1,0,0,0,0,0),  mkexp(0,0,0,0)};
        tbl[3]  = '{mkin(1,1,5'd7,0,5'd0,5'd1,5'd7,0,0,0,0,0,0),  mkexp(0,0,0,0)};
        tbl[4]  = '{mkin(1,1,5'd7,0,5'd0,5'd1,5'd7,1,0,0,0,0,0),  mkexp(1,0,0,0)};
        tbl[5]  = '{mkin(0,1,5'd8,0,5'd0,5'd8,5'd0,0,0,0,0,0,0),  mkexp(0,0,0,0)};
        tbl[6]  = '{mkin(0,1,5'd8,0,5'd0,5'd2,5'd8,0,1,0,0,0,0),  mkexp(1,0,0,0)};
        tbl[7]  = '{mkin(0,0,5'd0,1,5'd9,5'd9,5'd3,0,1,0,0,0,0),  mkexp(1,0,0,0)};
        tbl[8]  = '{mkin(0,0,5'd0,1,5'd0,5'd0,5'd0,0,1,0,0,0,0),  mkexp(0,0,0,0)};
        tbl[9]  = '{mkin(0,0,5'd0,0,5'd0,5'd4,5'd6,1,1,1,0,0,0),  mkexp(0,1,0,0)};
        tbl[10] = '{mkin(0,1,5'd4,0,5'd0,5'd4,5'd6,1,1,1,0,0,0),  mkexp(1,0,0,0)};
        tbl[11] = '{mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,0,1),  mkexp(0,0,0,0)};
        tbl[12] = '{mkin(1,1,5'd3,0,5'd0,5'd3,5'd0,0,0,0,1,0,0),  mkexp(1,0,0,0)};
        tbl[13] = '{mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0),  mkexp(0,0,0,0)};

        // Outputs forced low while reset is asserted, even with hazards present.
        RESET_N = 1'b0;
        drive(z);
        @(posedge CLOCK); #1;
        cyc(mkin(1,1,5'd5,0,5'd0,5'd5,5'd0,0,0,1,0,0,0), none, "reset_outputs");
`ifdef STALL_STATS_EN
        check_count(16'd0, "stats_reset");
`endif
        RESET_N = 1'b1;

        for (int i = 0; i < 14; i++) cyc(tbl[i].vi, tbl[i].ve, $sformatf("table[%0d]", i));

        // Branch after load: EX match then MEM match, then taken-branch flush.
        cyc(mkin(1,1,5'd8,0,5'd0,5'd8,5'd9,1,1,1,0,0,0), mkexp(1,0,0,0), "br_load_ex");
        cyc(mkin(0,0,5'd0,1,5'd8,5'd8,5'd9,1,1,1,0,0,0), mkexp(1,0,0,0), "br_load_mem");
        cyc(mkin(0,0,5'd0,0,5'd0,5'd8,5'd9,1,1,1,0,0,0), mkexp(0,1,0,0), "br_load_go");

        // MULT: busy t+1..t+4, done t+5, MFHI held until t+6.
        cyc(mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), none, "mult_start");
        for (int k = 1; k <= 5; k++)
            cyc(hl, mkexp(1, 0, k <= 4, k == 5), $sformatf("mult_t+%0d", k));
        cyc(hl, none, "mult_release");

        // DIV followed by a MULT waiting in ID.
        cyc(mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,1,1,0), none, "div_start");
        for (int k = 1; k <= 33; k++)
            cyc(mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0),
                mkexp(1, 0, k <= 32, k == 33), $sformatf("div_t+%0d", k));
        cyc(mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), none, "mult2_accept");
        for (int k = 35; k <= 39; k++)
            cyc(z, mkexp(0, 0, k <= 38, k == 39), $sformatf("mult2_t+%0d", k));
        cyc(z, none, "mult2_idle");

        // Reset in RUN with counter at 10 aborts the op without a done pulse.
        cyc(mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,1,1,0), none, "abort_start");
        for (int k = 1; k <= 21; k++) cyc(z, mkexp(0,0,1,0), $sformatf("abort_run+%0d", k));
        RESET_N = 1'b0;
        cyc(hl, none, "abort_reset_low");
        RESET_N = 1'b1;
        for (int k = 23; k <= 36; k++) cyc(hl, none, $sformatf("abort_after+%0d", k));

`ifdef STALL_STATS_EN
        RESET_N = 1'b0;
        cyc(z, none, "stats_clear");
        RESET_N = 1'b1;
        check_count(16'd0, "stats_cleared");
        for (int k = 0; k < 3; k++) begin
            cyc(lu, mkexp(1,0,0,0), "stats_lu");
            cyc(z, none, "stats_lu_gap");
        end
        cyc(mkin(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), none, "stats_mult");
        for (int k = 1; k <= 5; k++) cyc(hl, mkexp(1, 0, k <= 4, k == 5), "stats_mfhi");
        cyc(z, none, "stats_idle");
        check_count(16'd8, "stats_eight");
        drive(lu);
        repeat (70000) @(posedge CLOCK);
        #1;
        check_count(16'hFFFF, "stats_saturate");
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
